// File: rtl/kmkz_ibus_bridge_if.sv
// -----------------------------------------------------------------------------
// kmkz_ibus_bridge_if
//   Request/grant/rvalid instruction bus between the fetch bridge (master) and
//   the system instruction bus (slave).
//
//   req    master -> slave  request valid
//   addr   master -> slave  word-aligned request address, 0 while req=0
//   gnt    slave -> master  request accepted this cycle
//   rvalid slave -> master  response beat
//   rdata  slave -> master  response data
//   err    slave -> master  response is an error, qualified by rvalid
// -----------------------------------------------------------------------------
interface kmkz_ibus_bridge_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata,
        input  err
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata,
        output err
    );
endinterface

// File: rtl/kmkz_ibus_bridge.sv
// -----------------------------------------------------------------------------
// kmkz_ibus_bridge
//   Presents a "one-word synchronous memory" to the fetch FIFO: a ready_o pulse
//   delivers the word at the address the FIFO held on the previous cycle.
//   Behind that, one transaction at a time is run on a variable-latency
//   request/grant/rvalid bus. Branch flushes, bus errors, timeouts and stale
//   responses (FIFO address moved on while the beat was in flight) are handled
//   here so the FIFO only ever sees words that match its current address.
//
//   Parameters
//     TIMEOUT  WAIT cycles without rvalid before an error response is
//              synthesised; 0 disables the timeout.
//   Ports
//     clk_i     clock, rising edge
//     rst_i     asynchronous active-low reset
//     addr_i    fetch address from the FIFO, bits [1:0] ignored
//     branch_i  flush, highest priority
//     data_o    fetched word, valid while ready_o
//     ready_o   one-cycle delivery pulse (registered)
//     err_o     delivery faulted, data_o is 0 (registered)
//     ibus      bus master side
// -----------------------------------------------------------------------------
module kmkz_ibus_bridge #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [31:0]                addr_i,
    input  logic                       branch_i,
    output logic [31:0]                data_o,
    output logic                       ready_o,
    output logic                       err_o,
    kmkz_ibus_bridge_if.master         ibus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DROP,
        ST_RESP
    } state_t;

    localparam logic [8:0] TIMEOUT_W = 9'(TIMEOUT);

    state_t      state_reg, state_next;
    logic [29:0] addr_q_reg, addr_q_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic [31:0] data_reg, data_next;
    logic        err_reg, err_next;
    logic        ready_reg, ready_next;

    logic [8:0]  cnt_inc;
    logic        timeout_hit;
    logic        stale;

    // Byte-offset bits are don't-care for word fetches.
    logic        addr_lsb_unused;
    assign addr_lsb_unused = ^addr_i[1:0];

    // The counter holds the number of completed silent WAIT cycles, so the
    // current cycle is the TIMEOUT-th one when cnt_reg + 1 equals TIMEOUT.
    assign cnt_inc     = {1'b0, cnt_reg} + 9'd1;
    assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == TIMEOUT_W);
    assign stale       = (addr_i[31:2] != addr_q_reg);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg  <= ST_IDLE;
            addr_q_reg <= '0;
            cnt_reg    <= '0;
            data_reg   <= '0;
            err_reg    <= 1'b0;
            ready_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            addr_q_reg <= addr_q_next;
            cnt_reg    <= cnt_next;
            data_reg   <= data_next;
            err_reg    <= err_next;
            ready_reg  <= ready_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        addr_q_next = addr_q_reg;
        cnt_next    = cnt_reg;
        data_next   = data_reg;
        // err_o only ever qualifies the delivery pulse, so it drops back to 0
        // on every cycle that does not enter RESP.
        err_next    = 1'b0;
        ibus.req    = 1'b0;
        ibus.addr   = '0;

        unique case (state_reg)
            ST_IDLE: begin
                state_next = ST_REQ;
            end

            ST_REQ: begin
                // Address follows the FIFO until the bus accepts it.
                ibus.req  = 1'b1;
                ibus.addr = {addr_i[31:2], 2'b00};
                if (ibus.gnt) begin
                    addr_q_next = addr_i[31:2];
                    cnt_next    = '0;
                    state_next  = branch_i ? ST_DROP : ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (ibus.rvalid) begin
                    if (branch_i || stale) begin
                        state_next = ST_REQ;
                    end else begin
                        data_next  = ibus.err ? 32'h0 : ibus.rdata;
                        err_next   = ibus.err;
                        state_next = ST_RESP;
                    end
                end else if (branch_i) begin
                    state_next = ST_DROP;
                end else if (timeout_hit) begin
                    data_next  = 32'h0;
                    err_next   = 1'b1;
                    state_next = ST_RESP;
                end else begin
                    cnt_next = (cnt_reg == 8'hFF) ? cnt_reg : cnt_reg + 8'd1;
                end
            end

            ST_DROP: begin
                // The flushed beat still has to drain before a new request,
                // since only one transaction may be outstanding.
                if (ibus.rvalid) begin
                    state_next = ST_REQ;
                end
            end

            ST_RESP: begin
                state_next = ST_REQ;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        ready_next = (state_next == ST_RESP);
    end

    assign data_o  = data_reg;
    assign err_o   = err_reg;
    assign ready_o = ready_reg;

endmodule

// File: tb/tb_kmkz_ibus_bridge.sv
// -----------------------------------------------------------------------------
// tb_kmkz_ibus_bridge
//   Directed stimulus for kmkz_ibus_bridge (TIMEOUT=4). A transaction-level
//   model predicts requests and deliveries; a compare process checks the DUT
//   against it every cycle, and literal expectations pin both DUT and model
//   at hand-computed points of each scenario.
// -----------------------------------------------------------------------------
module tb_kmkz_ibus_bridge;

    localparam int unsigned TO = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [31:0] addr_i = 32'h0;
    logic        branch_i = 1'b0;
    logic [31:0] data_o;
    logic        ready_o;
    logic        err_o;

    kmkz_ibus_bridge_if ibus();

    kmkz_ibus_bridge #(.TIMEOUT(TO)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .addr_i   (addr_i),
        .branch_i (branch_i),
        .data_o   (data_o),
        .ready_o  (ready_o),
        .err_o    (err_o),
        .ibus     (ibus)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check1(input string name, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, want %b @%0t", name, got, exp, $time);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h, want %08h @%0t", name, got, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // m_live  : bridge has left reset and is issuing requests
    // m_out   : a granted transaction is outstanding
    // m_flush : that transaction was flushed by a branch
    // m_pulse : a delivery is visible on the outputs this cycle
    bit          m_live  = 1'b0;
    bit          m_out   = 1'b0;
    bit          m_flush = 1'b0;
    bit          m_pulse = 1'b0;
    bit          m_perr  = 1'b0;
    logic [29:0] m_word  = '0;
    logic [31:0] m_pdata = '0;
    int unsigned m_age   = 0;

    initial begin : model
        forever begin
            @(posedge clk_i);
            if (!rst_i) begin
                m_live = 0; m_out = 0; m_flush = 0; m_pulse = 0; m_perr = 0;
                m_word = '0; m_pdata = '0; m_age = 0;
            end else if (!m_live) begin
                m_live = 1;
            end else if (m_pulse) begin
                m_pulse = 0;
            end else if (!m_out) begin
                if (ibus.gnt) begin
                    m_out   = 1;
                    m_word  = addr_i[31:2];
                    m_flush = branch_i;
                    m_age   = 0;
                end
            end else if (ibus.rvalid) begin
                m_out = 0;
                if (!m_flush && !branch_i && addr_i[31:2] == m_word) begin
                    m_pulse = 1;
                    m_perr  = ibus.err;
                    m_pdata = ibus.err ? 32'h0 : ibus.rdata;
                end
            end else if (branch_i) begin
                m_flush = 1;
            end else if (!m_flush) begin
                m_age++;
                if (TO != 0 && m_age == TO) begin
                    m_out   = 0;
                    m_pulse = 1;
                    m_perr  = 1;
                    m_pdata = 32'h0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin : compare
        logic exp_req;
        logic exp_rdy;
        forever begin
            @(negedge clk_i);
            #1;
            exp_req = rst_i && m_live && !m_out && !m_pulse;
            exp_rdy = rst_i && m_pulse;
            check1("cyc.req", ibus.req, exp_req);
            check32("cyc.ibus_addr", ibus.addr, exp_req ? {addr_i[31:2], 2'b00} : 32'h0);
            check1("cyc.ready", ready_o, exp_rdy);
            if (exp_rdy) begin
                check32("cyc.data", data_o, m_pdata);
                check1("cyc.err", err_o, m_perr);
                $display("fetch @%0t data=%08h err=%0b", $time, data_o, err_o);
            end
            if (!rst_i) begin
                check32("cyc.rst_data", data_o, 32'h0);
                check1("cyc.rst_err", err_o, 1'b0);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drv(input logic [31:0] a, input logic br, input logic g,
                       input logic rv, input logic e, input logic [31:0] rd);
        @(negedge clk_i);
        addr_i      = a;
        branch_i    = br;
        ibus.gnt    = g;
        ibus.rvalid = rv;
        ibus.err    = e;
        ibus.rdata  = rd;
    endtask

    // Literal expectations for the cycle just driven.
    task automatic pin(input string name, input logic rdy, input logic [31:0] d,
                       input logic e, input logic rq, input logic [31:0] a);
        #2;
        check1({name, ".ready"}, ready_o, rdy);
        check1({name, ".model_ready"}, m_pulse, rdy);
        if (rdy) begin
            check32({name, ".data"}, data_o, d);
            check1({name, ".err"}, err_o, e);
            check32({name, ".model_data"}, m_pdata, d);
            check1({name, ".model_err"}, m_perr, e);
        end
        check1({name, ".req"}, ibus.req, rq);
        check32({name, ".addr"}, ibus.addr, a);
    endtask

    initial begin : stim
        ibus.gnt = 1'b0; ibus.rvalid = 1'b0; ibus.err = 1'b0; ibus.rdata = 32'h0;

        // Reset, including bus activity that must be ignored.
        drv(32'h100, 0, 0, 0, 0, 32'h0);          pin("rst0", 0, 0, 0, 0, 32'h0);
        drv(32'h100, 0, 1, 1, 0, 32'hFFFF_FFFF);  pin("rst1", 0, 0, 0, 0, 32'h0);
        drv(32'h100, 0, 0, 0, 0, 32'h0); rst_i = 1'b1; pin("rel", 0, 0, 0, 0, 32'h0);

        // Best-case fetch at 0x100.
        drv(32'h100, 0, 1, 0, 0, 32'h0);          pin("s1_req", 0, 0, 0, 1, 32'h100);
        drv(32'h100, 0, 0, 1, 0, 32'hDEADBEEF);   pin("s1_wait", 0, 0, 0, 0, 32'h0);
        drv(32'h102, 0, 0, 0, 0, 32'h0);          pin("s1_resp", 1, 32'hDEADBEEF, 0, 0, 32'h0);

        // Unaligned FIFO address, word address on the bus.
        drv(32'h102, 0, 1, 0, 0, 32'h0);          pin("s2_req", 0, 0, 0, 1, 32'h100);
        drv(32'h102, 0, 0, 1, 0, 32'h12345678);   pin("s2_wait", 0, 0, 0, 0, 32'h0);
        drv(32'h200, 0, 0, 0, 0, 32'h0);          pin("s2_resp", 1, 32'h12345678, 0, 0, 32'h0);

        // Stale response: FIFO moves to 0x204 while 0x200 is in flight.
        drv(32'h200, 0, 1, 0, 0, 32'h0);          pin("s3_req", 0, 0, 0, 1, 32'h200);
        drv(32'h204, 0, 0, 0, 0, 32'h0);          pin("s3_wait", 0, 0, 0, 0, 32'h0);
        drv(32'h204, 0, 0, 1, 0, 32'hAAAA0200);   pin("s3_beat", 0, 0, 0, 0, 32'h0);
        drv(32'h204, 0, 1, 0, 0, 32'h0);          pin("s3_rereq", 0, 0, 0, 1, 32'h204);
        drv(32'h204, 0, 0, 1, 0, 32'hBBBB0204);   pin("s3_wait2", 0, 0, 0, 0, 32'h0);
        drv(32'h300, 0, 0, 0, 0, 32'h0);          pin("s3_resp", 1, 32'hBBBB0204, 0, 0, 32'h0);

        // Branch in WAIT, beat 3 cycles later is dropped.
        drv(32'h300, 0, 1, 0, 0, 32'h0);          pin("s4_req", 0, 0, 0, 1, 32'h300);
        drv(32'h300, 1, 0, 0, 0, 32'h0);          pin("s4_wait", 0, 0, 0, 0, 32'h0);
        drv(32'h400, 0, 0, 0, 0, 32'h0);          pin("s4_drop1", 0, 0, 0, 0, 32'h0);
        drv(32'h400, 0, 0, 0, 0, 32'h0);          pin("s4_drop2", 0, 0, 0, 0, 32'h0);
        drv(32'h400, 0, 0, 1, 0, 32'hCCCC0300);   pin("s4_drop3", 0, 0, 0, 0, 32'h0);

        // Error response, then a clean fetch.
        drv(32'h400, 0, 1, 0, 0, 32'h0);          pin("s4_newreq", 0, 0, 0, 1, 32'h400);
        drv(32'h400, 0, 0, 1, 1, 32'h55555555);   pin("s5_wait", 0, 0, 0, 0, 32'h0);
        drv(32'h404, 0, 0, 0, 0, 32'h0);          pin("s5_err", 1, 32'h0, 1, 0, 32'h0);
        drv(32'h404, 0, 1, 0, 0, 32'h0);          pin("s5_req", 0, 0, 0, 1, 32'h404);
        drv(32'h404, 0, 0, 1, 0, 32'h0404ABCD);   pin("s5_wait2", 0, 0, 0, 0, 32'h0);
        drv(32'h500, 0, 0, 0, 0, 32'h0);          pin("s5_ok", 1, 32'h0404ABCD, 0, 0, 32'h0);

        // Timeout after 4 silent WAIT cycles; stray beat afterwards ignored.
        drv(32'h500, 0, 1, 0, 0, 32'h0);          pin("s6_req", 0, 0, 0, 1, 32'h500);
        for (int i = 0; i < 4; i++) begin
            drv(32'h500, 0, 0, 0, 0, 32'h0);      pin("s6_wait", 0, 0, 0, 0, 32'h0);
        end
        drv(32'h500, 0, 0, 0, 0, 32'h0);          pin("s6_timeout", 1, 32'h0, 1, 0, 32'h0);
        drv(32'h500, 0, 0, 1, 0, 32'hEEEE0000);   pin("s6_stray", 0, 0, 0, 1, 32'h500);
        drv(32'h500, 0, 0, 0, 0, 32'h0);          pin("s6_still", 0, 0, 0, 1, 32'h500);
        drv(32'h500, 0, 1, 0, 0, 32'h0);          pin("s6_rereq", 0, 0, 0, 1, 32'h500);
        drv(32'h500, 0, 0, 1, 0, 32'h0500F00D);   pin("s6_wait2", 0, 0, 0, 0, 32'h0);
        drv(32'h600, 0, 0, 0, 0, 32'h0);          pin("s6_after", 1, 32'h0500F00D, 0, 0, 32'h0);

        // Branch together with grant: straight to DROP.
        drv(32'h600, 1, 1, 0, 0, 32'h0);          pin("s7_req", 0, 0, 0, 1, 32'h600);
        drv(32'h700, 0, 0, 0, 0, 32'h0);          pin("s7_drop", 0, 0, 0, 0, 32'h0);
        drv(32'h700, 0, 0, 1, 0, 32'h11110600);   pin("s7_beat", 0, 0, 0, 0, 32'h0);

        // Branch without grant stays in REQ; branch during RESP keeps the pulse.
        drv(32'h700, 1, 0, 0, 0, 32'h0);          pin("s8_req_br", 0, 0, 0, 1, 32'h700);
        drv(32'h704, 0, 0, 0, 0, 32'h0);          pin("s8_req", 0, 0, 0, 1, 32'h704);
        drv(32'h704, 0, 1, 0, 0, 32'h0);          pin("s8_gnt", 0, 0, 0, 1, 32'h704);
        drv(32'h704, 0, 0, 1, 0, 32'h0704C0DE);   pin("s8_wait", 0, 0, 0, 0, 32'h0);
        drv(32'h708, 1, 0, 0, 0, 32'h0);          pin("s8_resp_br", 1, 32'h0704C0DE, 0, 0, 32'h0);
        drv(32'h708, 0, 0, 0, 0, 32'h0);          pin("s8_after", 0, 0, 0, 1, 32'h708);

        // Reset mid-transaction; a late beat after release lands in REQ.
        drv(32'h708, 0, 1, 0, 0, 32'h0);          pin("s9_req", 0, 0, 0, 1, 32'h708);
        drv(32'h708, 0, 0, 0, 0, 32'h0); rst_i = 1'b0; pin("s9_rst", 0, 0, 0, 0, 32'h0);
        drv(32'h708, 0, 0, 0, 0, 32'h0); rst_i = 1'b1; pin("s9_rel", 0, 0, 0, 0, 32'h0);
        drv(32'h708, 0, 0, 1, 0, 32'hDEAD0708);   pin("s9_late", 0, 0, 0, 1, 32'h708);
        drv(32'h708, 0, 0, 0, 0, 32'h0);          pin("s9_still", 0, 0, 0, 1, 32'h708);
        drv(32'h708, 0, 1, 0, 0, 32'h0);          pin("s9_gnt", 0, 0, 0, 1, 32'h708);
        drv(32'h708, 0, 0, 1, 0, 32'h0708BEEF);   pin("s9_wait", 0, 0, 0, 0, 32'h0);
        drv(32'h70C, 0, 0, 0, 0, 32'h0);          pin("s9_resp", 1, 32'h0708BEEF, 0, 0, 32'h0);

        drv(32'h70C, 0, 0, 0, 0, 32'h0);
        drv(32'h70C, 0, 0, 0, 0, 32'h0);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
